// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the pipeline sequencer: controller state encoding and the
// drain countdown type used while the memory stage retires after HALT.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } ctrl_state_t;

    // Wide enough for a drain length of 1..7 cycles (loaded with length-1).
    typedef logic [2:0] drain_cnt_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// -----------------------------------------------------------------------------
// pipeline_controller_if
// Bundles the controller's status inputs and latch controls so the datapath
// and benches can connect through one handle.
//   ctrl modport : controller view (status in, latch controls out)
//   tb   modport : stimulus/monitor view (status out, latch controls in)
// -----------------------------------------------------------------------------
interface pipeline_controller_if #(
    parameter int CNT_W = 32
);
    logic             ihit, dhit, dmem_req, branch_taken, jump, load_use, halt;
    logic             pc_en;
    logic             fetch_en, fetch_flush, decode_en, decode_flush;
    logic             execute_en, execute_flush, memory_en, memory_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;

    modport ctrl (
        input  ihit, dhit, dmem_req, branch_taken, jump, load_use, halt,
        output pc_en, fetch_en, fetch_flush, decode_en, decode_flush,
               execute_en, execute_flush, memory_en, memory_flush,
               halted, stall_cycles, flush_cycles
    );

    modport tb (
        output ihit, dhit, dmem_req, branch_taken, jump, load_use, halt,
        input  pc_en, fetch_en, fetch_flush, decode_en, decode_flush,
               execute_en, execute_flush, memory_en, memory_flush,
               halted, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
// Free-running event counter, wraps modulo 2^CNT_W.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (clears count)
//   inc_i   : count one event this cycle
//   clear_i : synchronous clear, takes priority over inc_i
//   count_o : current count
// -----------------------------------------------------------------------------
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (inc_i)
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/pipeline_controller.sv
// -----------------------------------------------------------------------------
// pipeline_controller
// Sequences the PC and the F/D, D/E, E/M, M/W latches from cache status,
// hazard flags and HALT, and counts stall and flush cycles.
//   CLK, nRST                 : clock / async active-low reset
//   ihit, dhit, dmem_req      : cache status
//   branch_taken, jump,
//   load_use, halt            : hazard / control flags
//   pc_en, *_en, *_flush      : latch controls (flush only with its en)
//   halted                    : sticky stop indication
//   stall_cycles/flush_cycles : performance counters
//
// state   | meaning
// RUN     | normal issue, priority decode of hazards
// MEMWAIT | data cache miss outstanding, same decode as RUN
// DRAIN   | HALT accepted, only M/W keeps moving
// HALTED  | everything stopped until reset
// -----------------------------------------------------------------------------
module pipeline_controller
    import cpu_types_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             load_use,
    input  logic             halt,
    output logic             pc_en,
    output logic             fetch_en,
    output logic             fetch_flush,
    output logic             decode_en,
    output logic             decode_flush,
    output logic             execute_en,
    output logic             execute_flush,
    output logic             memory_en,
    output logic             memory_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);
    localparam drain_cnt_t DRAIN_LOAD = drain_cnt_t'(DRAIN_CYCLES - 1);

    ctrl_state_t state_q, state_d;
    drain_cnt_t  drain_q, drain_d;
    logic        mem_busy;
    logic        active;

    assign mem_busy = dmem_req & ~dhit;
    assign active   = (state_q == RUN) || (state_q == MEMWAIT);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: begin
                if (mem_busy)
                    state_d = MEMWAIT;
                else if (halt) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            MEMWAIT: begin
                // HALT only leaves once the memory stage is no longer busy.
                if (halt && !mem_busy) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (dhit)
                    state_d = RUN;
            end
            DRAIN: begin
                if (drain_q == '0)
                    state_d = HALTED;
                else
                    drain_d = drain_q - 3'd1;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        pc_en         = 1'b0;
        fetch_en      = 1'b0;
        fetch_flush   = 1'b0;
        decode_en     = 1'b0;
        decode_flush  = 1'b0;
        execute_en    = 1'b0;
        execute_flush = 1'b0;
        memory_en     = 1'b0;
        memory_flush  = 1'b0;
        if (active) begin
            if (mem_busy) begin
                // full freeze: nothing moves
            end else if (halt) begin
                memory_en = 1'b1;
            end else if (branch_taken) begin
                {pc_en, fetch_en, decode_en, execute_en, memory_en} = '1;
                fetch_flush  = 1'b1;
                decode_flush = 1'b1;
            end else if (jump) begin
                {pc_en, fetch_en, decode_en, execute_en, memory_en} = '1;
                fetch_flush = 1'b1;
            end else if (load_use) begin
                // hold F/D, bubble into D/E
                decode_en    = 1'b1;
                decode_flush = 1'b1;
                execute_en   = 1'b1;
                memory_en    = 1'b1;
            end else if (!ihit) begin
                // hold PC, bubble into F/D while the icache fills
                fetch_en    = 1'b1;
                fetch_flush = 1'b1;
                decode_en   = 1'b1;
                execute_en  = 1'b1;
                memory_en   = 1'b1;
            end else begin
                {pc_en, fetch_en, decode_en, execute_en, memory_en} = '1;
            end
        end else if (state_q == DRAIN) begin
            memory_en = 1'b1;
        end
    end

    assign halted = (state_q == HALTED);

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (active & ~pc_en),
        .clear_i (1'b0),
        .count_o (stall_cycles)
    );

    // fetch_flush is never raised outside RUN/MEMWAIT, so this freezes too.
    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (fetch_flush),
        .clear_i (1'b0),
        .count_o (flush_cycles)
    );
endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Central sequencer for the 5-stage pipeline latches: fetch (F/D), decode (D/E), execute (E/M), memory (M/W), plus the PC register.
- Drives every latch's en/flush pair from cache hit status, hazard flags and halt.
- Owns a small FSM (RUN / MEMWAIT / DRAIN / HALTED) and performance counters for stall and flush cycles.
- Sits beside the datapath. Its outputs connect directly to each latch interface's flush and en inputs and to pc_en.

Parameters:
- CNT_W, 32, width of stall_cycles and flush_cycles counters.
- DRAIN_CYCLES, 1, cycles the M/W latch keeps running after halt before halted asserts. Legal range 1..7.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  icache returned instruction this cycle.
- dhit  in  1  dcache completed the memory-stage request this cycle.
- dmem_req  in  1  memory-stage instruction is a load or store (dREN|dWEN).
- branch_taken  in  1  execute stage resolved a taken branch or JR.
- jump  in  1  decode stage holds J/JAL.
- load_use  in  1  decode source register matches the execute-stage load destination.
- halt  in  1  memory stage holds HALT.
- pc_en  out  1  PC register update enable.
- fetch_en, fetch_flush  out  1 each  F/D latch control.
- decode_en, decode_flush  out  1 each  D/E latch control.
- execute_en, execute_flush  out  1 each  E/M latch control.
- memory_en, memory_flush  out  1 each  M/W latch control.
- halted  out  1  pipeline fully stopped, sticky until reset.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0 in RUN/MEMWAIT.
- flush_cycles  out  CNT_W  count of cycles with fetch_flush=1.

Behaviour:
- Interface: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values:
  - state=RUN, both counters=0, halted=0.
  - Control outputs follow the RUN decode below (combinational from state and inputs).
- Latch convention: a flush output is only ever asserted together with its en=1. A latch with en=1, flush=1 loads zeros (a bubble).
- mem_busy = dmem_req & ~dhit.
- State transitions:
  - RUN -> MEMWAIT when mem_busy.
  - MEMWAIT -> RUN on dhit.
  - RUN or MEMWAIT -> DRAIN when halt & ~mem_busy. The drain counter loads DRAIN_CYCLES-1.
  - DRAIN -> HALTED when the drain counter reaches 0. Otherwise decrement.
  - HALTED is absorbing until nRST.
- RUN/MEMWAIT decode, first match wins:
  1. mem_busy: all en=0, pc_en=0, no flush (full freeze).
  2. halt: pc_en=0, fetch/decode/execute en=0, memory_en=1.
  3. branch_taken: pc_en=1, all en=1, fetch_flush=1, decode_flush=1. Wins over jump, load_use and ~ihit.
  4. jump: pc_en=1, all en=1, fetch_flush=1.
  5. load_use: pc_en=0, fetch_en=0, decode_en=1 with decode_flush=1, execute/memory en=1.
  6. ~ihit: pc_en=0, fetch_en=1 with fetch_flush=1, downstream en=1.
  7. Otherwise: all en=1, pc_en=1, no flush.
- DRAIN: memory_en=1, all other en=0, pc_en=0.
- HALTED: every en, flush and pc_en is 0; halted=1.
- Counters:
  - Each increments by 1 per qualifying cycle and wraps modulo 2^CNT_W.
  - Both freeze in DRAIN and HALTED.
- Edge cases:
  - nRST asserted mid-MEMWAIT or mid-DRAIN returns to RUN immediately; counters clear.
  - halt together with mem_busy stays in RUN/MEMWAIT until dhit.

Decomposition:
- cpu_types_pkg: add the ctrl_state_t enum (RUN, MEMWAIT, DRAIN, HALTED) and a 3-bit drain count type.
- pipeline_controller_if interface with modports ctrl and tb, mirroring the existing latch interfaces.
- One natural sub-module, perf_counter: CNT_W-bit counter with inc and clear inputs, instantiated twice.

Test Plan:
- Reset with all inputs 0 except ihit=1 -> all en=1, pc_en=1, counters 0, halted=0.
- dmem_req=1, dhit=0 for 3 cycles, then dhit=1 -> state MEMWAIT for 3 cycles with all en=0; stall_cycles=3; RUN resumes on the dhit cycle.
- branch_taken=1 and load_use=1 in the same cycle -> pc_en=1, fetch_flush=1, decode_flush=1, fetch_en=1; flush_cycles increments by 1.
- load_use=1 for one cycle with ihit=1 -> pc_en=0, fetch_en=0, decode_flush=1; stall_cycles +1.
- ihit=0 for 2 cycles -> fetch_flush=1 each cycle, pc_en=0; stall_cycles +2, flush_cycles +2.
- halt=1 with DRAIN_CYCLES=2 -> memory_en=1 for 2 further cycles, then halted=1 and all outputs 0. Pulse nRST low mid-DRAIN -> immediate return to RUN, counters 0.
